reg_wb_scoreboard: RTL and testbench
====================================

// Module: reg_wb_scoreboard
// PURPOSE
//  Writeback stage and register scoreboard directly upstream of the 32x32 register file.
//  Tracks outstanding writes per architectural register, registers retiring results,
//  and drives the reg file write port. Gives the issue stage busy/forward info for two source operands.
//  Reg 0 is never tracked, written or forwarded.
// PARAMETERS
//  DATA_WIDTH  32  register data width
//  ADDR_WIDTH  5   register address width (2**ADDR_WIDTH registers)
//  CNT_WIDTH   2   per-register pending-write counter width; saturates at 2**CNT_WIDTH-1
// PORTS
//  clk          in   1           clock, all state updates on posedge
//  rst_n        in   1           asynchronous reset, active low
//  iss_valid    in   1           issue stage dispatching an instr that writes iss_waddr
//  iss_waddr    in   ADDR_WIDTH  destination register of dispatched instr
//  iss_ready    out  1           dispatch accepted this cycle (combinational)
//  rs1_addr     in   ADDR_WIDTH  source operand 1 query
//  rs2_addr     in   ADDR_WIDTH  source operand 2 query
//  rs1_busy     out  1           rs1 not yet readable; issue must stall
//  rs2_busy     out  1           rs2 not yet readable; issue must stall
//  rs1_fwd      out  1           rs1 value comes from rs1_fwd_data, not reg file
//  rs2_fwd      out  1           rs2 value comes from rs2_fwd_data, not reg file
//  rs1_fwd_data out  DATA_WIDTH  forwarded value for rs1
//  rs2_fwd_data out  DATA_WIDTH  forwarded value for rs2
//  ret_valid    in   1           result retiring this cycle (always accepted)
//  ret_waddr    in   ADDR_WIDTH  retiring destination
//  ret_wdata    in   DATA_WIDTH  retiring result
//  rf_wen       out  1           reg file write enable (registered)
//  rf_waddr     out  ADDR_WIDTH  reg file write address (registered)
//  rf_wdata     out  DATA_WIDTH  reg file write data (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): all counters 0; rf_wen=0, rf_waddr=0, rf_wdata=0; so all busy/fwd outputs 0.
//  Counters: cnt[r] = writes dispatched to r and not yet committed to the reg file.
//  - iss_ready = !(iss_valid && iss_waddr!=0 && cnt[iss_waddr]==MAX). Dispatch fires on iss_valid&&iss_ready.
//  - iss_waddr==0: always ready, no counter change.
//  - Commit = rf_wen high at a posedge: reg file writes rf_waddr, and cnt[rf_waddr] decrements the same edge.
//  - Fire and commit on the same reg in the same edge: cnt unchanged. Different regs: both applied.
//  - Commit with cnt already 0 (protocol error): cnt stays 0, no underflow.
//  WB register (latency 1): at each posedge the WB register loads:
//  - rf_wen  <= ret_valid && ret_waddr!=0
//  - rf_waddr <= ret_waddr
//  - rf_wdata <= ret_wdata
//  - It drives the reg file for exactly one cycle. No back-pressure; one retire per cycle max.
//  Operand status for rsN (combinational, N=1,2):
//  - hit = rf_wen && rf_waddr==rsN_addr && rsN_addr!=0
//  - rsN_fwd = hit && cnt[rsN_addr]==1 (WB holds the youngest pending write)
//  - rsN_fwd_data = rf_wdata when rsN_fwd, else 0
//  - rsN_busy = rsN_addr!=0 && cnt[rsN_addr]!=0 && !rsN_fwd
//  - Dispatch in the same cycle does not affect that cycle's busy/fwd (counters are read pre-update).
//  In-order retire to the same register is the caller's contract; the block does not reorder.
//  Reset mid-operation: pending counts and the in-flight WB write are discarded (no rf write after reset).
// TESTING
//  1. Reset:
//     rst_n=0 mid-run with cnt[5]=2 and rf_wen=1 -> async: rf_wen=0, rs*_busy=0, cnt all 0 after release.
//  2. Basic flow:
//     dispatch r3; next cycle rs1_addr=3 -> rs1_busy=1.
//     ret r3=0xDEADBEEF -> next cycle rf_wen=1, rf_waddr=3, rs1_fwd=1, rs1_fwd_data=0xDEADBEEF, busy=0.
//     Following cycle -> reg file r3=0xDEADBEEF, cnt[3]=0.
//  3. Multiple pending:
//     dispatch r7 twice; retire first (0x11) -> rs2_busy=1, rs2_fwd=0.
//     Retire second (0x22) -> rs2_fwd=1, data 0x22.
//  4. Saturation:
//     dispatch r9 three times -> 4th: iss_ready=0, cnt stays 3.
//     Same cycle as a r9 commit: iss_ready still 0 (pre-update check), cnt 3->2.
//  5. Simultaneous:
//     dispatch r4 while r4 commits with cnt[4]=1 -> cnt[4]=1 after edge, rs1_busy=1 next cycle.
//  6. Reg 0:
//     dispatch/retire r0 with data 0x5 -> iss_ready=1, rf_wen=0, rs1_addr=0 gives busy=0, fwd=0.

Source files
------------

// File: rtl/reg_wb_scoreboard.sv
// Writeback register and per-register pending-write scoreboard placed in front
// of the register file. Counts dispatched-but-uncommitted writes per register,
// holds each retiring result for one cycle as the reg file write, and reports
// busy/forward status for two source operands. Register 0 is never tracked.
module reg_wb_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_waddr,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rs1_fwd,
    output logic                  rs2_fwd,
    output logic [DATA_WIDTH-1:0] rs1_fwd_data,
    output logic [DATA_WIDTH-1:0] rs2_fwd_data,
    input  logic                  ret_valid,
    input  logic [ADDR_WIDTH-1:0] ret_waddr,
    input  logic [DATA_WIDTH-1:0] ret_wdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int                   NREGS   = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  r_cnt [NREGS];
    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;

    logic                  w_fire;
    logic [NREGS-1:0]      w_inc;
    logic [NREGS-1:0]      w_dec;
    logic [1:0]            w_rs1_status;
    logic [1:0]            w_rs2_status;

    // Status of one source operand: {busy, fwd}. Forwarding is only legal when
    // the write sitting in WB is the last one outstanding for that register.
    function automatic logic [1:0] f_status(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [CNT_WIDTH-1:0]  cnt,
        input logic                  wen,
        input logic [ADDR_WIDTH-1:0] waddr
    );
        logic hit;
        logic fwd;
        logic busy;
        hit  = wen && (waddr == addr) && (addr != '0);
        fwd  = hit && (cnt == CNT_ONE);
        busy = (addr != '0) && (cnt != '0) && !fwd;
        return {busy, fwd};
    endfunction

    // Dispatch is refused only when the destination counter is already full;
    // the check uses the counter before this edge's commit is applied.
    assign iss_ready = !(iss_valid && (iss_waddr != '0) && (r_cnt[iss_waddr] == CNT_MAX));
    assign w_fire    = iss_valid && iss_ready && (iss_waddr != '0);

    // Per-register increment (dispatch) and decrement (commit) requests.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_inc[i] = w_fire && (iss_waddr == ADDR_WIDTH'(i));
            w_dec[i] = r_rf_wen && (r_rf_waddr == ADDR_WIDTH'(i)) && (r_cnt[i] != '0);
        end
    end

    // Pending-write counters; simultaneous inc and dec on one register cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                else if (w_dec[i] && !w_inc[i])
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
            end
        end
    end

    // Writeback register: captures each retiring result for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_wen   <= ret_valid && (ret_waddr != '0);
            r_rf_waddr <= ret_waddr;
            r_rf_wdata <= ret_wdata;
        end
    end

    assign w_rs1_status = f_status(rs1_addr, r_cnt[rs1_addr], r_rf_wen, r_rf_waddr);
    assign w_rs2_status = f_status(rs2_addr, r_cnt[rs2_addr], r_rf_wen, r_rf_waddr);

    assign rs1_busy     = w_rs1_status[1];
    assign rs1_fwd      = w_rs1_status[0];
    assign rs2_busy     = w_rs2_status[1];
    assign rs2_fwd      = w_rs2_status[0];
    assign rs1_fwd_data = rs1_fwd ? r_rf_wdata : '0;
    assign rs2_fwd_data = rs2_fwd ? r_rf_wdata : '0;

    assign rf_wen   = r_rf_wen;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Directed bench for reg_wb_scoreboard with a small register file model fed
// from the write port. Inputs change 1 time unit after posedge; combinational
// outputs are checked 2 units after posedge.
module tb_reg_wb_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        iss_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
    logic        ret_valid;
    logic [4:0]  ret_waddr;
    logic [31:0] ret_wdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [31:0] tb_rf [32];
    int          n_checks;
    int          n_errors;

    reg_wb_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iss_valid    (iss_valid),
        .iss_waddr    (iss_waddr),
        .iss_ready    (iss_ready),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_fwd      (rs1_fwd),
        .rs2_fwd      (rs2_fwd),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data),
        .ret_valid    (ret_valid),
        .ret_waddr    (ret_waddr),
        .ret_wdata    (ret_wdata),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model driven by the write port.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) tb_rf[i] <= 32'h0;
        end else if (rf_wen) begin
            tb_rf[rf_waddr] <= rf_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic retire(input logic [4:0] a, input logic [31:0] d);
        ret_valid = 1'b1;
        ret_waddr = a;
        ret_wdata = d;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        iss_valid = 1'b0;
        iss_waddr = '0;
        rs1_addr  = '0;
        rs2_addr  = '0;
        ret_valid = 1'b0;
        ret_waddr = '0;
        ret_wdata = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        // Reset state
        rs1_addr = 5'd3;
        rs2_addr = 5'd7;
        settle();
        check("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
        check("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_busy1", {31'b0, rs1_busy}, 32'd0);
        check("rst_busy2", {31'b0, rs2_busy}, 32'd0);

        // Basic flow on r3
        tick();
        iss_valid = 1'b1;
        iss_waddr = 5'd3;
        settle();
        check("b_iss_ready", {31'b0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0;
        settle();
        check("b_busy", {31'b0, rs1_busy}, 32'd1);
        check("b_nofwd", {31'b0, rs1_fwd}, 32'd0);
        retire(5'd3, 32'hDEADBEEF);
        tick();
        ret_valid = 1'b0;
        settle();
        check("b_rf_wen", {31'b0, rf_wen}, 32'd1);
        check("b_rf_waddr", {27'b0, rf_waddr}, 32'd3);
        check("b_fwd", {31'b0, rs1_fwd}, 32'd1);
        check("b_fwd_data", rs1_fwd_data, 32'hDEADBEEF);
        check("b_busy_wb", {31'b0, rs1_busy}, 32'd0);
        tick();
        settle();
        check("b_rf3", tb_rf[3], 32'hDEADBEEF);
        check("b_wen_off", {31'b0, rf_wen}, 32'd0);
        check("b_busy_done", {31'b0, rs1_busy}, 32'd0);

        // Two pending writes to r7
        iss_valid = 1'b1;
        iss_waddr = 5'd7;
        tick();
        tick();
        iss_valid = 1'b0;
        settle();
        check("m_busy0", {31'b0, rs2_busy}, 32'd1);
        retire(5'd7, 32'h11);
        tick();
        retire(5'd7, 32'h22);
        settle();
        check("m_busy1", {31'b0, rs2_busy}, 32'd1);
        check("m_nofwd1", {31'b0, rs2_fwd}, 32'd0);
        check("m_fwd_data0", rs2_fwd_data, 32'h0);
        tick();
        ret_valid = 1'b0;
        settle();
        check("m_fwd2", {31'b0, rs2_fwd}, 32'd1);
        check("m_fwd_data2", rs2_fwd_data, 32'h22);
        check("m_busy2", {31'b0, rs2_busy}, 32'd0);
        check("m_rf7_first", tb_rf[7], 32'h11);
        tick();
        settle();
        check("m_busy_done", {31'b0, rs2_busy}, 32'd0);
        check("m_rf7", tb_rf[7], 32'h22);

        // Saturation on r9
        rs1_addr  = 5'd9;
        iss_valid = 1'b1;
        iss_waddr = 5'd9;
        tick();
        tick();
        tick();
        settle();
        check("s_full_ready", {31'b0, iss_ready}, 32'd0);
        check("s_busy", {31'b0, rs1_busy}, 32'd1);
        tick();
        retire(5'd9, 32'hA1);
        tick();
        ret_valid = 1'b0;
        settle();
        check("s_ready_pre", {31'b0, iss_ready}, 32'd0);
        check("s_nofwd_cnt3", {31'b0, rs1_fwd}, 32'd0);
        tick();
        settle();
        check("s_ready_after", {31'b0, iss_ready}, 32'd1);
        iss_valid = 1'b0;
        retire(5'd9, 32'hA2);
        tick();
        retire(5'd9, 32'hA3);
        settle();
        check("s_nofwd_cnt2", {31'b0, rs1_fwd}, 32'd0);
        check("s_busy_cnt2", {31'b0, rs1_busy}, 32'd1);
        tick();
        ret_valid = 1'b0;
        settle();
        check("s_fwd_cnt1", {31'b0, rs1_fwd}, 32'd1);
        check("s_fwd_data", rs1_fwd_data, 32'hA3);
        tick();
        settle();
        check("s_busy_done", {31'b0, rs1_busy}, 32'd0);

        // Dispatch and commit of r4 on the same edge
        rs1_addr  = 5'd4;
        iss_valid = 1'b1;
        iss_waddr = 5'd4;
        tick();
        iss_valid = 1'b0;
        retire(5'd4, 32'h44);
        tick();
        ret_valid = 1'b0;
        iss_valid = 1'b1;
        iss_waddr = 5'd4;
        settle();
        check("x_ready", {31'b0, iss_ready}, 32'd1);
        check("x_fwd_pre", {31'b0, rs1_fwd}, 32'd1);
        tick();
        iss_valid = 1'b0;
        settle();
        check("x_busy_after", {31'b0, rs1_busy}, 32'd1);
        check("x_rf4", tb_rf[4], 32'h44);
        retire(5'd4, 32'h45);
        tick();
        ret_valid = 1'b0;
        tick();
        settle();
        check("x_busy_done", {31'b0, rs1_busy}, 32'd0);

        // Register 0
        rs1_addr  = 5'd0;
        iss_valid = 1'b1;
        iss_waddr = 5'd0;
        retire(5'd0, 32'h5);
        settle();
        check("z_ready", {31'b0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0;
        ret_valid = 1'b0;
        settle();
        check("z_rf_wen", {31'b0, rf_wen}, 32'd0);
        check("z_busy", {31'b0, rs1_busy}, 32'd0);
        check("z_fwd", {31'b0, rs1_fwd}, 32'd0);

        // Commit with no pending dispatch must not underflow
        rs1_addr = 5'd10;
        retire(5'd10, 32'h77);
        tick();
        ret_valid = 1'b0;
        settle();
        check("u_fwd_cnt0", {31'b0, rs1_fwd}, 32'd0);
        check("u_busy_cnt0", {31'b0, rs1_busy}, 32'd0);
        tick();
        settle();
        check("u_busy_after", {31'b0, rs1_busy}, 32'd0);

        // Asynchronous reset mid-operation
        rs1_addr  = 5'd5;
        iss_valid = 1'b1;
        iss_waddr = 5'd5;
        tick();
        tick();
        iss_valid = 1'b0;
        retire(5'd5, 32'h55);
        tick();
        ret_valid = 1'b0;
        settle();
        check("r_pre_wen", {31'b0, rf_wen}, 32'd1);
        check("r_pre_busy", {31'b0, rs1_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("r_async_wen", {31'b0, rf_wen}, 32'd0);
        check("r_async_busy", {31'b0, rs1_busy}, 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        settle();
        check("r_post_wen", {31'b0, rf_wen}, 32'd0);
        check("r_post_busy", {31'b0, rs1_busy}, 32'd0);
        check("r_post_ready", {31'b0, iss_ready}, 32'd1);
        check("r_rf5", tb_rf[5], 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
